logic_unit_sched: RTL and testbench
===================================

// Module: logic_unit_sched
// PURPOSE
//  Sequencer/arbiter sharing one combinational 32-bit logic unit (AND/OR/NOR/NOT) between two requesters.
//  Round-robin grant, one op in flight; single-pass ops take 1 LU cycle.
//  BUF maps to OR(A,A); XOR is sequenced as 4 LU passes with an internal temp register.
//  Sits between decode/control and the shared logic unit in the CPU datapath.
// PARAMETERS
//  DATA_WIDTH  32     operand/result width (datapath fixed at 32)
//  ERR_DATA    32'h0  RSP_DATA value returned with RSP_ERR
// PORTS
//  CLK         in   1   clock, rising edge
//  RST         in   1   synchronous reset, active-low
//  REQ0_VALID  in   1   requester 0 has an op
//  REQ0_READY  out  1   requester 0 op accepted this cycle
//  REQ0_OP     in   3   opcode: 000 AND,001 OR,010 NOR,011 NOT,100 BUF,101 XOR,11x illegal
//  REQ0_A      in   32  operand A
//  REQ0_B      in   32  operand B (ignored for NOT/BUF)
//  REQ1_*      --   --  same set as REQ0_* for requester 1
//  RSP_VALID   out  1   result valid
//  RSP_READY   in   1   consumer takes result
//  RSP_ID      out  1   requester that owns the result
//  RSP_DATA    out  32  result
//  RSP_ERR     out  1   illegal/disabled opcode
//  LU_OP       out  2   to shared unit: 00 AND,01 OR,10 NOR,11 NOT(A)
//  LU_A        out  32  shared-unit operand A
//  LU_B        out  32  shared-unit operand B
//  LU_Y        in   32  shared-unit combinational result
// BEHAVIOUR
//  Reset (RST=0 at edge): state=IDLE, PRIO=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ERR=0, READYs=0, LU_OP=00, LU_A=LU_B=0.
//  Reset mid-op aborts silently: no response for the in-flight op.
//  Grant (IDLE only, combinational): one VALID -> that requester; both -> PRIO. REQn_READY=1 only for the grantee.
//  Accept = VALID&READY. Latch ID, OP, A, B; PRIO <= ~ID.
//  READY=0 in every non-IDLE state. VALID held without READY must hold its payload.
//  States: IDLE, EXEC, X1, X2, X3, RESP.
//   IDLE -> EXEC on legal accept; IDLE -> RESP with ERR=1, DATA=ERR_DATA on illegal accept.
//   EXEC: drive LU from latched op (BUF: OR with B=A); non-XOR: RSP_DATA<=LU_Y, -> RESP.
//   XOR: EXEC T<=A|B; X1 U<=A&B; X2 U<=~U (LU NOT); X3 RSP_DATA<=T&U -> RESP.
//   RESP: RSP_VALID=1, payload stable until RSP_READY=1 at an edge -> IDLE.
//  Latency, accept edge = cycle 0: single-pass RSP_VALID at cycle 2; XOR at cycle 5; illegal at cycle 1.
//  Throughput: next accept no earlier than the cycle after response handshake (min 3-cycle op period).
//  LU_OP/A/B are 0 in IDLE and RESP. In EXEC..X3 they are driven from registers only (no REQ->LU path).
//  RSP_READY high before RSP_VALID has no effect. Both VALIDs high forever: strict alternation.
// CONFIGURATION
//  LOGIC_SEQ_XOR_EN defined: XOR (101) sequenced as above; X1..X3 and T/U regs present.
//  Not defined: 101 is illegal -> ERR response at cycle 1, DATA=ERR_DATA; X1..X3 and T/U removed.
// TESTING
//  REQ0 AND A=F0F0_F0F0 B=FF00_FF00 -> RSP_DATA=F000_F000, ID=0, RSP_VALID at cycle 2.
//  REQ1 NOT A=0000_FFFF; then BUF A=1234_5678 -> FFFF_0000; then 1234_5678, LU_OP=01, LU_B=LU_A.
//  XOR_EN: XOR A=AAAA_AAAA B=FFFF_0000 -> 5555_AAAA at cycle 5. No XOR_EN: ERR=1, DATA=0 at cycle 1.
//  Both VALID, OR ops, 4 back-to-back -> RSP_ID 0,1,0,1; each READY pulses exactly once per op.
//  RSP_READY=0 for 10 cycles -> RSP_* stable, both READYs 0; release -> IDLE, next grant next cycle.
//  RST=0 during XOR X2 -> next edge all outputs at reset values, PRIO=0; no stale response afterwards.

Source files
------------

// File: rtl/logic_unit_sched.sv
// Purpose : shares one combinational logic unit (AND/OR/NOR/NOT) between two requesters with round-robin grant.
// Latency : from the accept edge, RSP_VALID shows after 2 cycles for single-pass ops, 5 for XOR and 1 for illegal ops.
// Backpress: one op in flight; both READYs stay low outside IDLE, and the response holds until rsp_ready.
//
// Ports:
//   clk, rst                  clock (rising edge) and synchronous active-low reset
//   req{0,1}_valid/ready      request handshake; payload is req{0,1}_op (3b), _a, _b
//   rsp_valid/ready           response handshake; payload is rsp_id, rsp_data, rsp_err
//   lu_op/lu_a/lu_b, lu_y     drive to and result from the shared logic unit
//
// Optional feature: define LOGIC_SEQ_XOR_EN to sequence XOR (op 101) as four logic-unit passes.
// Without it, 101 is treated as an illegal opcode.
module logic_unit_sched #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [1:0]            lu_op,
    output logic [DATA_WIDTH-1:0] lu_a,
    output logic [DATA_WIDTH-1:0] lu_b,
    input  logic [DATA_WIDTH-1:0] lu_y
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_NOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_BUF = 3'b100;
`ifdef LOGIC_SEQ_XOR_EN
    localparam logic [2:0] OP_XOR = 3'b101;
`endif

    localparam logic [1:0] LU_AND = 2'b00;
    localparam logic [1:0] LU_OR  = 2'b01;
    localparam logic [1:0] LU_NOR = 2'b10;
    localparam logic [1:0] LU_NOT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
`ifdef LOGIC_SEQ_XOR_EN
        X1,
        X2,
        X3,
`endif
        RESP
    } state_t;

    state_t state, state_nxt;

    logic                  prio;
    logic                  grant_id;
    logic                  accept;
    logic [2:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;
    logic                  sel_legal;
    logic [2:0]            lat_op;
    logic [DATA_WIDTH-1:0] lat_a, lat_b;
`ifdef LOGIC_SEQ_XOR_EN
    logic [DATA_WIDTH-1:0] t_reg, u_reg;
`endif

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_NOR, OP_NOT, OP_BUF: op_legal = 1'b1;
`ifdef LOGIC_SEQ_XOR_EN
            OP_XOR:                                op_legal = 1'b1;
`endif
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    // Grant: a lone requester wins outright; on contention PRIO decides.
    // READY is also held low while reset is asserted so nothing looks accepted.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? prio : (req1_valid && !req0_valid);
        req0_ready = (state == IDLE) && rst && (req0_valid || req1_valid) && !grant_id;
        req1_ready = (state == IDLE) && rst && (req0_valid || req1_valid) &&  grant_id;
        accept     = req0_ready || req1_ready;
        sel_op     = grant_id ? req1_op : req0_op;
        sel_a      = grant_id ? req1_a  : req0_a;
        sel_b      = grant_id ? req1_b  : req0_b;
        sel_legal  = op_legal(sel_op);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = sel_legal ? EXEC : RESP;
`ifdef LOGIC_SEQ_XOR_EN
            EXEC: state_nxt = (lat_op == OP_XOR) ? X1 : RESP;
            X1:   state_nxt = X2;
            X2:   state_nxt = X3;
            X3:   state_nxt = RESP;
`else
            EXEC: state_nxt = RESP;
`endif
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: the logic unit is fed only from latched registers, never from the request ports.
    always_comb begin
        rsp_valid = (state == RESP);
        lu_op     = LU_AND;
        lu_a      = '0;
        lu_b      = '0;
        case (state)
            EXEC: begin
                lu_a = lat_a;
                lu_b = lat_b;
                case (lat_op)
                    OP_AND: lu_op = LU_AND;
                    OP_OR:  lu_op = LU_OR;
                    OP_NOR: lu_op = LU_NOR;
                    OP_NOT: lu_op = LU_NOT;
                    OP_BUF: begin
                        lu_op = LU_OR;   // BUF is OR(A, A)
                        lu_b  = lat_a;
                    end
`ifdef LOGIC_SEQ_XOR_EN
                    OP_XOR: lu_op = LU_OR;   // T = A | B
`endif
                    default: begin
                        lu_a = '0;
                        lu_b = '0;
                    end
                endcase
            end
`ifdef LOGIC_SEQ_XOR_EN
            // XOR = (A | B) & ~(A & B)
            X1: begin
                lu_op = LU_AND;
                lu_a  = lat_a;
                lu_b  = lat_b;
            end
            X2: begin
                lu_op = LU_NOT;
                lu_a  = u_reg;
            end
            X3: begin
                lu_op = LU_AND;
                lu_a  = t_reg;
                lu_b  = u_reg;
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio     <= 1'b0;
            rsp_id   <= 1'b0;
            lat_op   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
`ifdef LOGIC_SEQ_XOR_EN
            t_reg    <= '0;
            u_reg    <= '0;
`endif
        end else begin
            if (accept) begin
                rsp_id  <= grant_id;
                lat_op  <= sel_op;
                lat_a   <= sel_a;
                lat_b   <= sel_b;
                prio    <= ~grant_id;
                rsp_err <= ~sel_legal;
                if (!sel_legal) rsp_data <= ERR_DATA;
            end
            case (state)
`ifdef LOGIC_SEQ_XOR_EN
                EXEC: begin
                    if (lat_op == OP_XOR) t_reg    <= lu_y;
                    else                  rsp_data <= lu_y;
                end
                X1: u_reg    <= lu_y;
                X2: u_reg    <= lu_y;
                X3: rsp_data <= lu_y;
`else
                EXEC: rsp_data <= lu_y;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_sched.sv
module tb_logic_unit_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [1:0]  lu_op;
    logic [31:0] lu_a, lu_b, lu_y;

    int checks = 0;
    int errors = 0;
    int acc0 = 0;
    int acc1 = 0;
    logic cnt_en = 1'b0;
    logic [1:0]  f_op;
    logic [31:0] f_a, f_b;

    always #5 clk = ~clk;

    logic_unit_sched #(.DATA_WIDTH(32), .ERR_DATA(32'h0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y)
    );

    // Shared logic unit model
    always_comb begin
        case (lu_op)
            2'b00:   lu_y = lu_a & lu_b;
            2'b01:   lu_y = lu_a | lu_b;
            2'b10:   lu_y = ~(lu_a | lu_b);
            default: lu_y = ~lu_a;
        endcase
    end

    always @(posedge clk) begin
        if (cnt_en) begin
            if (req0_valid && req0_ready) acc0++;
            if (req1_valid && req1_ready) acc1++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it the same way.
    task automatic run_op(input logic who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic early, input logic [31:0] exp_d, input logic exp_e,
                          input int exp_lat, input string tag);
        int lat;
        rsp_ready = early;
        if (who) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        @(negedge clk);
        chk({tag, "_ready"}, {30'b0, req1_ready, req0_ready}, who ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        f_op = lu_op; f_a = lu_a; f_b = lu_b;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  lat,      exp_lat);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_id"},   {31'b0, rsp_id},  {31'b0, who});
        chk({tag, "_err"},  {31'b0, rsp_err}, {31'b0, exp_e});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic stale;
        rst = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl",  {rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, lu_op}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_lua",  lu_a, 32'd0);
        chk("rst_lub",  lu_b, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 1'b0, 2, "and");
        chk("and_luop", {30'b0, f_op}, 32'd0);
        chk("and_lua",  f_a, 32'hF0F0_F0F0);
        run_op(1'b1, 3'b011, 32'h0000_FFFF, 32'h0, 1'b0, 32'hFFFF_0000, 1'b0, 2, "not");
        chk("not_luop", {30'b0, f_op}, 32'd3);
        run_op(1'b1, 3'b100, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 1'b0, 2, "buf");
        chk("buf_luop", {30'b0, f_op}, 32'd1);
        chk("buf_lua",  f_a, 32'h1234_5678);
        chk("buf_lub",  f_b, 32'h1234_5678);
`ifdef LOGIC_SEQ_XOR_EN
        run_op(1'b0, 3'b101, 32'hAAAA_AAAA, 32'hFFFF_0000, 1'b0, 32'h5555_AAAA, 1'b0, 5, "xor");
`else
        run_op(1'b0, 3'b101, 32'hAAAA_AAAA, 32'hFFFF_0000, 1'b0, 32'h0, 1'b1, 1, "xor_off");
`endif
        run_op(1'b0, 3'b110, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0, 1'b1, 1, "illegal");
        run_op(1'b1, 3'b010, 32'h0F0F_0000, 32'h0000_0F0F, 1'b1, 32'hF0F0_F0F0, 1'b0, 2, "nor_early");

        // Both requesters valid: last grant went to 1, so order is 0,1,0,1.
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'h1;  req0_b = 32'h2;
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'h10; req1_b = 32'h20;
        rsp_ready = 1'b1;
        cnt_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            @(negedge clk);
            while (!rsp_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("alt_timeout", {31'b0, rsp_valid}, 32'd1);
            chk("alt_id",   {31'b0, rsp_id}, k % 2);
            chk("alt_data", rsp_data, (k % 2 == 1) ? 32'h30 : 32'h3);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        cnt_en = 1'b0;
        chk("acc0_count", acc0, 32'd2);
        chk("acc1_count", acc1, 32'd2);

        // Response stall with a second requester waiting.
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'h0000_00F0; req0_b = 32'h0000_0F00;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'hFFFF_0000; req1_b = 32'h0F0F_0F0F;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_ctl",  {rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, lu_op}, 32'h40);
            chk("stall_data", rsp_data, 32'h0000_0FF0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("next_grant", {30'b0, req1_ready, req0_ready}, 32'd2);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("after_stall_data", rsp_data, 32'h0F0F_0000);
        chk("after_stall_id",   {31'b0, rsp_id}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset in the middle of an op (X2 of XOR when sequencing is built in).
`ifdef LOGIC_SEQ_XOR_EN
        req0_valid = 1'b1; req0_op = 3'b101; req0_a = 32'hAAAA_AAAA; req0_b = 32'hFFFF_0000;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`else
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'hAAAA_AAAA; req0_b = 32'hFFFF_0000;
        @(posedge clk); #1;
        req0_valid = 1'b0;
`endif
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000;
        req1_valid = 1'b1; req1_op = 3'b000;
        @(negedge clk);
        chk("midrst_lu_live", {30'b0, lu_op}, {30'b0, lu_op});
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ctl",  {rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, lu_op}, 32'd0);
        chk("midrst_data", rsp_data, 32'd0);
        chk("midrst_lua",  lu_a, 32'd0);
        chk("midrst_lub",  lu_b, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_prio", {30'b0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1'b1;
        end
        chk("no_stale_rsp", {31'b0, stale}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
